// File: rtl/block_sync_mlane.sv
// Multi-lane 64b/66b block synchroniser: per-lane sync-header hunt, lock
// qualification with good/bad hysteresis, and registered aligned block output.
module block_sync_mlane #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned BLOCK_W    = 66,
    parameter int unsigned BUF_W      = 2 * BLOCK_W,
    parameter int unsigned OFF_W      = $clog2(BLOCK_W),
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned UNLOCK_BAD = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [LANES-1:0]           data_valid_i,
    input  logic [LANES*BUF_W-1:0]     data_buf_i,
    input  logic [LANES-1:0]           force_resync_i,
    output logic [LANES*OFF_W-1:0]     offset_o,
    output logic [LANES-1:0]           lock_o,
    output logic [LANES*BLOCK_W-1:0]   block_o,
    output logic [LANES-1:0]           block_valid_o,
    output logic [LANES-1:0]           hdr_err_o
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_BAD + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TEST   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        state_e               state_q, state_d;
        logic [OFF_W-1:0]     offset_q, offset_d;
        logic [GOOD_W-1:0]    good_q, good_d;
        logic [WIN_W-1:0]     win_q, win_d;
        logic [BAD_W-1:0]     bad_q, bad_d;
        logic                 lock_q, lock_d;
        logic                 bv_q, bv_d;
        logic                 herr_q, herr_d;
        logic [BLOCK_W-1:0]   block_q, block_d;

        logic [BUF_W-1:0]     window_c;
        logic [BLOCK_W-1:0]   aligned_c;
        logic [1:0]           hdr_c;
        logic                 hdr_good_c;
        logic [OFF_W-1:0]     slip_c;

        // Window extraction at the current offset; header is the low two bits
        assign window_c   = data_buf_i[n*BUF_W +: BUF_W];
        assign aligned_c  = BLOCK_W'(window_c >> offset_q);
        assign hdr_c      = aligned_c[1:0];
        assign hdr_good_c = (hdr_c == 2'b01) || (hdr_c == 2'b10);
        assign slip_c     = (offset_q == OFF_W'(BLOCK_W - 1)) ? '0 : offset_q + OFF_W'(1);

        // Lane state register and output flops
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q  <= HUNT;
                offset_q <= '0;
                good_q   <= '0;
                win_q    <= '0;
                bad_q    <= '0;
                lock_q   <= 1'b0;
                bv_q     <= 1'b0;
                herr_q   <= 1'b0;
                block_q  <= '0;
            end else begin
                state_q  <= state_d;
                offset_q <= offset_d;
                good_q   <= good_d;
                win_q    <= win_d;
                bad_q    <= bad_d;
                lock_q   <= lock_d;
                bv_q     <= bv_d;
                herr_q   <= herr_d;
                block_q  <= block_d;
            end
        end

        // Hunt/test/locked next-state, counters and per-valid output strobes
        always_comb begin
            state_d  = state_q;
            offset_d = offset_q;
            good_d   = good_q;
            win_d    = win_q;
            bad_d    = bad_q;
            block_d  = block_q;
            bv_d     = 1'b0;
            herr_d   = 1'b0;
            if (force_resync_i[n]) begin
                state_d  = HUNT;
                offset_d = '0;
                good_d   = '0;
                win_d    = '0;
                bad_d    = '0;
            end else if (data_valid_i[n]) begin
                herr_d = !hdr_good_c;
                if (state_q == LOCKED) begin
                    bv_d    = 1'b1;
                    block_d = aligned_c;
                end
                unique case (state_q)
                    HUNT: begin
                        if (hdr_good_c) begin
                            if (LOCK_CNT == 1) begin
                                state_d = LOCKED;
                                good_d  = '0;
                            end else begin
                                state_d = TEST;
                                good_d  = GOOD_W'(1);
                            end
                        end else begin
                            offset_d = slip_c;
                        end
                    end
                    TEST: begin
                        if (hdr_good_c) begin
                            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_d = LOCKED;
                                good_d  = '0;
                                win_d   = '0;
                                bad_d   = '0;
                            end else begin
                                good_d = good_q + GOOD_W'(1);
                            end
                        end else begin
                            state_d  = HUNT;
                            offset_d = slip_c;
                            good_d   = '0;
                        end
                    end
                    LOCKED: begin
                        // Unlock outranks the window rollover on the same valid
                        if (!hdr_good_c && (bad_q == BAD_W'(UNLOCK_BAD - 1))) begin
                            state_d = HUNT;
                            good_d  = '0;
                            win_d   = '0;
                            bad_d   = '0;
                        end else if (win_q == WIN_W'(WINDOW - 1)) begin
                            win_d = '0;
                            bad_d = '0;
                        end else begin
                            win_d = win_q + WIN_W'(1);
                            if (!hdr_good_c) begin
                                bad_d = bad_q + BAD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
            lock_d = (state_d == LOCKED);
        end

        assign offset_o[n*OFF_W +: OFF_W]     = offset_q;
        assign lock_o[n]                      = lock_q;
        assign block_o[n*BLOCK_W +: BLOCK_W]  = block_q;
        assign block_valid_o[n]               = bv_q;
        assign hdr_err_o[n]                   = herr_q;
    end

endmodule

// File: tb/tb_block_sync_mlane.sv
// Directed bench for block_sync_mlane with a per-cycle scoreboard model.
module tb_block_sync_mlane;

    localparam int unsigned LANES      = 4;
    localparam int unsigned BLOCK_W    = 66;
    localparam int unsigned BUF_W      = 2 * BLOCK_W;
    localparam int unsigned OFF_W      = $clog2(BLOCK_W);
    localparam int unsigned LOCK_CNT   = 32;
    localparam int unsigned WINDOW     = 64;
    localparam int unsigned UNLOCK_BAD = 16;

    typedef struct packed {
        logic [LANES*OFF_W-1:0]   off;
        logic [LANES-1:0]         lock;
        logic [LANES*BLOCK_W-1:0] blk;
        logic [LANES-1:0]         bv;
        logic [LANES-1:0]         he;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [LANES-1:0]         valid;
    logic [LANES-1:0]         resync;
    logic [BUF_W-1:0]         win [LANES];
    logic [LANES*BUF_W-1:0]   data_buf;
    logic [LANES*OFF_W-1:0]   offset_o;
    logic [LANES-1:0]         lock_o;
    logic [LANES*BLOCK_W-1:0] block_o;
    logic [LANES-1:0]         bv_o;
    logic [LANES-1:0]         herr_o;

    always_comb begin
        for (int n = 0; n < LANES; n++) data_buf[n*BUF_W +: BUF_W] = win[n];
    end

    block_sync_mlane #(
        .LANES(LANES), .BLOCK_W(BLOCK_W), .BUF_W(BUF_W), .OFF_W(OFF_W),
        .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .UNLOCK_BAD(UNLOCK_BAD)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .data_valid_i   (valid),
        .data_buf_i     (data_buf),
        .force_resync_i (resync),
        .offset_o       (offset_o),
        .lock_o         (lock_o),
        .block_o        (block_o),
        .block_valid_o  (bv_o),
        .hdr_err_o      (herr_o)
    );

    // Reference model state (0=hunt, 1=test, 2=locked)
    int               m_st [LANES];
    int               m_off [LANES];
    int               m_g [LANES];
    int               m_w [LANES];
    int               m_b [LANES];
    logic [BLOCK_W-1:0] m_blk [LANES];
    exp_t             q [$];
    int               checks = 0;
    int               errors = 0;
    int               herr_seen [LANES];
    int               vcount [LANES];

    task automatic model_reset();
        for (int n = 0; n < LANES; n++) begin
            m_st[n] = 0; m_off[n] = 0; m_g[n] = 0; m_w[n] = 0; m_b[n] = 0;
            m_blk[n] = '0; herr_seen[n] = 0; vcount[n] = 0;
        end
    endtask

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance the model for the driven inputs, push expectation, clock, compare
    task automatic tick();
        exp_t             e;
        logic [BUF_W-1:0] sh;
        logic [1:0]       h;
        bit               good;
        e = '0;
        for (int n = 0; n < LANES; n++) begin
            if (resync[n]) begin
                m_st[n] = 0; m_off[n] = 0; m_g[n] = 0; m_w[n] = 0; m_b[n] = 0;
            end else if (valid[n]) begin
                vcount[n]++;
                sh   = win[n] >> m_off[n];
                h    = sh[1:0];
                good = (h == 2'b01) || (h == 2'b10);
                e.he[n] = !good;
                if (m_st[n] == 2) begin
                    e.bv[n]  = 1'b1;
                    m_blk[n] = BLOCK_W'(sh);
                end
                case (m_st[n])
                    0: begin
                        if (good) begin
                            m_g[n] = 1; m_st[n] = 1;
                        end else begin
                            m_off[n] = (m_off[n] == BLOCK_W - 1) ? 0 : m_off[n] + 1;
                        end
                    end
                    1: begin
                        if (good) begin
                            m_g[n]++;
                            if (m_g[n] == LOCK_CNT) begin
                                m_st[n] = 2; m_g[n] = 0; m_w[n] = 0; m_b[n] = 0;
                            end
                        end else begin
                            m_off[n] = (m_off[n] == BLOCK_W - 1) ? 0 : m_off[n] + 1;
                            m_g[n] = 0; m_st[n] = 0;
                        end
                    end
                    default: begin
                        m_w[n]++;
                        if (!good) m_b[n]++;
                        if (m_b[n] == UNLOCK_BAD) begin
                            m_st[n] = 0; m_w[n] = 0; m_b[n] = 0; m_g[n] = 0;
                        end else if (m_w[n] == WINDOW) begin
                            m_w[n] = 0; m_b[n] = 0;
                        end
                    end
                endcase
            end
            e.off[n*OFF_W +: OFF_W]     = OFF_W'(m_off[n]);
            e.lock[n]                   = (m_st[n] == 2);
            e.blk[n*BLOCK_W +: BLOCK_W] = m_blk[n];
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        for (int n = 0; n < LANES; n++) if (herr_o[n] === 1'b1) herr_seen[n]++;
        checks++;
        assert (offset_o === e.off) else begin
            errors++; $error("FAIL sb_offset: observed %h expected %h", offset_o, e.off);
        end
        checks++;
        assert (lock_o === e.lock) else begin
            errors++; $error("FAIL sb_lock: observed %b expected %b", lock_o, e.lock);
        end
        checks++;
        assert (block_o === e.blk) else begin
            errors++; $error("FAIL sb_block: observed %h expected %h", block_o, e.blk);
        end
        checks++;
        assert (bv_o === e.bv) else begin
            errors++; $error("FAIL sb_block_valid: observed %b expected %b", bv_o, e.bv);
        end
        checks++;
        assert (herr_o === e.he) else begin
            errors++; $error("FAIL sb_hdr_err: observed %b expected %b", herr_o, e.he);
        end
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    logic [BUF_W-1:0] w0, w11, w1;
    int lv0, lv1, cyc;

    initial begin
        w0  = '0; w0[6] = 1'b1;                 // header 2'b10 at offset 5
        w11 = '0; w11[6] = 1'b1; w11[5] = 1'b1; // header 2'b11 at offset 5
        w1  = '0; w1[41] = 1'b1;                // header 2'b10 at offset 40
        rst_n = 1'b0; valid = '0; resync = '0;
        for (int n = 0; n < LANES; n++) win[n] = '0;
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_offset", longint'(offset_o), 0);
        chk("reset_lock", longint'(lock_o), 0);
        chk("reset_bv", longint'(bv_o), 0);
        chk("reset_herr", longint'(herr_o), 0);

        // Acquire on lane 0 at offset 5
        valid = 4'b0001; win[0] = w0;
        ticks(36);
        chk("acq_lock_36", longint'(lock_o[0]), 0);
        tick();
        chk("acq_lock_37", longint'(lock_o[0]), 1);
        chk("acq_herr_cnt", herr_seen[0], 5);
        chk("acq_offset", longint'(offset_o[OFF_W-1:0]), 5);
        tick();
        chk("acq_bv", longint'(bv_o[0]), 1);
        chk("acq_block", longint'(block_o[BLOCK_W-1:0] === BLOCK_W'(2)), 1);

        // Window with 15 bad headers keeps lock
        win[0] = '0;  ticks(15);
        win[0] = w0;  ticks(48);
        chk("hyst_15_lock", longint'(lock_o[0]), 1);
        // 16 bad headers in one window unlock
        win[0] = '0;  ticks(15);
        chk("hyst_15b_lock", longint'(lock_o[0]), 1);
        tick();
        chk("hyst_16_unlock", longint'(lock_o[0]), 0);
        chk("hyst_16_offset", longint'(offset_o[OFF_W-1:0]), 5);
        // Relock, then 15 bad on each side of a window boundary
        win[0] = w0;  ticks(32);
        chk("relock", longint'(lock_o[0]), 1);
        ticks(49);
        win[0] = '0;  ticks(30);
        win[0] = w0;  ticks(49);
        chk("hyst_split_lock", longint'(lock_o[0]), 1);

        // Asynchronous reset mid-stream while locked
        rst_n = 1'b0;
        #2;
        chk("arst_offset", longint'(offset_o), 0);
        chk("arst_lock", longint'(lock_o), 0);
        chk("arst_block", longint'(block_o === '0), 1);
        chk("arst_bv", longint'(bv_o), 0);
        chk("arst_herr", longint'(herr_o), 0);
        model_reset();
        q.delete();
        #2 rst_n = 1'b1;
        valid = '0;
        tick();
        chk("post_rst_offset", longint'(offset_o), 0);
        chk("post_rst_lock", longint'(lock_o), 0);

        // TEST abort at good_cnt 20
        valid = 4'b0001; win[0] = w0;
        ticks(25);
        chk("test_offset", longint'(offset_o[OFF_W-1:0]), 5);
        win[0] = w11;
        tick();
        chk("abort_offset", longint'(offset_o[OFF_W-1:0]), 6);
        chk("abort_herr", longint'(herr_o[0]), 1);
        chk("abort_lock", longint'(lock_o[0]), 0);

        // Offset wrap over an all-zero window
        resync = 4'b0001;
        tick();
        chk("rs_offset", longint'(offset_o[OFF_W-1:0]), 0);
        chk("rs_herr", longint'(herr_o[0]), 0);
        resync = '0; win[0] = '0; herr_seen[0] = 0;
        ticks(66);
        chk("wrap_offset", longint'(offset_o[OFF_W-1:0]), 0);
        tick();
        chk("wrap_herr_cnt", herr_seen[0], 67);
        chk("wrap_offset_1", longint'(offset_o[OFF_W-1:0]), 1);
        chk("wrap_lock", longint'(lock_o[0]), 0);

        // Force resync on locked lane 1 with a coincident good valid
        resync = 4'b0011; tick(); resync = '0;
        valid = 4'b0011; win[0] = w0; win[1] = w1;
        ticks(72);
        chk("both_lock", longint'(lock_o[1:0]), 3);
        chk("l1_offset", longint'(offset_o[2*OFF_W-1:OFF_W]), 40);
        resync = 4'b0010;
        tick();
        resync = '0;
        chk("frs_l1_offset", longint'(offset_o[2*OFF_W-1:OFF_W]), 0);
        chk("frs_l1_lock", longint'(lock_o[1]), 0);
        chk("frs_l1_bv", longint'(bv_o[1]), 0);
        chk("frs_l1_herr", longint'(herr_o[1]), 0);
        chk("frs_l0_lock", longint'(lock_o[0]), 1);
        chk("frs_l0_bv", longint'(bv_o[0]), 1);

        // Random valid gaps; lock counted in valids only
        resync = 4'b1111; tick(); resync = '0;
        for (int n = 0; n < LANES; n++) vcount[n] = 0;
        lv0 = -1; lv1 = -1; cyc = 0;
        while ((lv0 < 0 || lv1 < 0) && cyc < 3000) begin
            valid = LANES'($urandom);
            tick();
            if (lv0 < 0 && lock_o[0] === 1'b1) lv0 = vcount[0];
            if (lv1 < 0 && lock_o[1] === 1'b1) lv1 = vcount[1];
            cyc++;
        end
        valid = '0;
        chk("gap_l0_valids", lv0, 37);
        chk("gap_l1_valids", lv1, 72);
        chk("gap_l0_offset", longint'(offset_o[OFF_W-1:0]), 5);
        chk("gap_l1_offset", longint'(offset_o[2*OFF_W-1:OFF_W]), 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_sync_mlane.md
# block_sync_mlane

Parametrised multi-lane block synchroniser for the 64b/66b receive path. It sits after the per-lane gearboxes. For each lane it hunts for the 2-bit sync-header position inside the gearbox window and qualifies lock with consecutive-good and windowed-bad hysteresis. Each locked lane gets a registered, aligned block output. It generalises the single-lane offset search with lane count, block width, lock/unlock thresholds and forced resync.

## Interface
- LANES, 4, number of independent lanes
- BLOCK_W, 66, block width including 2-bit header
- BUF_W, 2*BLOCK_W, per-lane window width; must be ≥ 2*BLOCK_W-1
- OFF_W, $clog2(BLOCK_W), offset width
- LOCK_CNT, 32, consecutive good headers needed to lock
- WINDOW, 64, evaluated blocks per unlock window while locked
- UNLOCK_BAD, 16, bad headers within one window that force unlock

Ports:
- clk_i  in  1  single clock, all logic rising-edge
- rst_ni  in  1  asynchronous, active-low reset
- data_valid_i  in  LANES  per-lane strobe: window holds a new block candidate
- data_buf_i  in  LANES*BUF_W  lane n window at [n*BUF_W +: BUF_W]
- force_resync_i  in  LANES  per-lane forced return to hunt
- offset_o  out  LANES*OFF_W  current header offset per lane
- lock_o  out  LANES  lane locked
- block_o  out  LANES*BLOCK_W  aligned block: window[offset +: BLOCK_W]
- block_valid_o  out  LANES  block_o lane valid
- hdr_err_o  out  LANES  one-cycle pulse per evaluated bad header

## Operation
- Lanes are fully independent; all per-lane logic is replicated.
- Header check: hdr = window[offset+1 : offset]. Good iff hdr is 2'b01 or 2'b10. It is evaluated only on a data_valid_i cycle, using the offset register value in that cycle.
- Slip: offset ← (offset == BLOCK_W-1) ? 0 : offset+1. The new offset applies from the next valid.
- States per lane: HUNT, TEST, LOCKED. Counters are good_cnt, win_cnt and bad_cnt.
- HUNT, on valid:
  - good: good_cnt ← 1, go to TEST. If LOCK_CNT == 1, go directly to LOCKED.
  - bad: slip and stay in HUNT.
- TEST, on valid:
  - good: good_cnt++. When it reaches LOCK_CNT, go to LOCKED and clear all counters.
  - bad: slip, clear good_cnt, go to HUNT.
- LOCKED, on valid:
  - win_cnt++. A bad header also increments bad_cnt.
  - If bad_cnt reaches UNLOCK_BAD: go to HUNT with offset unchanged and counters cleared.
  - Otherwise, if win_cnt reaches WINDOW: clear win_cnt and bad_cnt and stay locked.
  - Unlock takes priority over the window rollover on the same valid.
- force_resync_i[n] has priority over everything, including a coincident valid. It sets state to HUNT, offset to 0 and all counters to 0. That cycle's header is not evaluated, and no hdr_err or block_valid is produced.
- data_valid_i low: state, offset and counters hold.
- Counter widths are sized for their thresholds; no counter wraps.

## Timing
- Reset: state HUNT, offset_o=0, lock_o=0, block_o=0, block_valid_o=0, hdr_err_o=0, all counters 0. Reset mid-operation aborts immediately (asynchronous).
- Every output is registered, with 1-cycle latency from the valid that caused it.
- lock_o = registered (state == LOCKED). It rises the cycle after the LOCK_CNT-th consecutive good valid and falls the cycle after the unlocking valid or a force_resync.
- block_valid_o[n] is high one cycle after valid[n] if the lane was LOCKED when the valid was evaluated. This includes the valid that causes an unlock.
- block_o is extracted with the pre-update offset.
- hdr_err_o is high one cycle after any evaluated bad header, in any state.
- offset_o updates one cycle after a slip.

## Test plan
- **Reset:** assert rst_ni low mid-stream with lane 0 locked → all outputs 0 asynchronously; after release, offset_o=0 and lock_o=0.
- **Acquire:** lane 0 window is all zero except bits[6:5]=2'b10, valid every cycle →
  - five hdr_err pulses while offset steps 0→5;
  - lock_o[0] rises one cycle after the 37th valid;
  - offset_o=5 and block_valid_o follows.
- **Hysteresis:** once locked, inject 15 bad headers within 64 valids → lock stays high. Inject 16 within one window → lock_o falls one cycle after the 16th bad, with offset still 5. Inject 15 bad in each of two consecutive windows → lock held.
- **TEST abort and wrap:**
  - a bad header at good_cnt=20 → back to HUNT with offset 6;
  - an all-zero window for 67 valids → offset walks 0..65 then wraps to 0, with 67 hdr_err pulses and no lock.
- **Force resync:** force_resync_i[1] coincident with a good valid on locked lane 1 →
  - lane 1 goes to offset 0 and lock 0, with no block_valid or hdr_err for that cycle;
  - lane 0 is unaffected.
- **Gaps and independence:** random data_valid_i gaps during acquire, with different offsets on each lane (offset 5 on lane 0, 40 on lane 1) → lock timing is counted in valids only, and each lane locks to its own offset.
